// File: rtl/uart_rx_param_if.sv
// Consumer-side handshake bundle of the parametrised UART receiver.
// The receiver drives the word and its flags; the consumer drives rx_ready.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_error;
  logic                 frame_error;
  logic                 overrun_error;

  modport master (
    output rx_data,
    output rx_valid,
    output parity_error,
    output frame_error,
    output overrun_error,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  parity_error,
    input  frame_error,
    input  overrun_error,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver paced by an external oversampling tick, valid/ready output.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting on data, parity and stop samples.
module uart_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_EN   = 1,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rxd,
  input  logic             sample_tick,
  output logic             busy,
  uart_rx_param_if.master  rx_bus
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 deliver;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;
  logic                   sample_bit;

  // Synchroniser resets to the idle line level so reset never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] CNT_VOTE_A = CNT_W'(OVERSAMPLE - 3);
  localparam logic [CNT_W-1:0] CNT_VOTE_B = CNT_W'(OVERSAMPLE - 2);

  logic vote_a_q;
  logic vote_b_q;

  // The two earlier votes are latched; the third is the live sample at the decision tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vote_a_q <= 1'b0;
      vote_b_q <= 1'b0;
    end else if (sample_tick && (state_q == DATA || state_q == PARITY || state_q == STOP)) begin
      if (cnt_q == CNT_VOTE_A) vote_a_q <= rxd_s;
      if (cnt_q == CNT_VOTE_B) vote_b_q <= rxd_s;
    end
  end

  assign sample_bit = (vote_a_q & vote_b_q) | (vote_a_q & rxd_s) | (vote_b_q & rxd_s);
`else
  assign sample_bit = rxd_s;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    deliver = 1'b0;

    if (sample_tick) begin
      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_d = START;
            cnt_d   = '0;
          end
        end

        START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_d = '0;
            if (!rxd_s) begin
              state_d = DATA;
              idx_d   = '0;
              perr_d  = 1'b0;
              ferr_d  = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d          = '0;
            shift_d[idx_q] = sample_bit;
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        PARITY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            perr_d  = (PARITY_EN != 0) & ((^shift_q) ^ sample_bit ^ (PARITY_ODD != 0));
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (!sample_bit) ferr_d = 1'b1;
            // Leaving mid stop bit lets a start edge immediately after this bit be caught.
            if (idx_q == STOP_LAST) begin
              idx_d   = '0;
              state_d = IDLE;
              deliver = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // A completed frame is dropped only if the previous word is still unaccepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_bus.rx_data       <= '0;
      rx_bus.rx_valid      <= 1'b0;
      rx_bus.parity_error  <= 1'b0;
      rx_bus.frame_error   <= 1'b0;
      rx_bus.overrun_error <= 1'b0;
    end else begin
      rx_bus.overrun_error <= 1'b0;
      if (deliver) begin
        if (!rx_bus.rx_valid || rx_bus.rx_ready) begin
          rx_bus.rx_data      <= shift_q;
          rx_bus.parity_error <= perr_q;
          rx_bus.frame_error  <= ferr_d;
          rx_bus.rx_valid     <= 1'b1;
        end else begin
          rx_bus.overrun_error <= 1'b1;
        end
      end else if (rx_bus.rx_valid && rx_bus.rx_ready) begin
        rx_bus.rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: a line driver pushes expected words, a monitor pops them on accept.
// Covers directed cases plus randomized frames, ready back-pressure and sample_tick gaps.
module tb_uart_rx_param;

  localparam int DB = 8;
  localparam int OS = 16;
  localparam int PE = 1;
  localparam int PO = 0;
  localparam int SB = 1;

  typedef struct packed {
    logic [DB-1:0] data;
    logic          perr;
    logic          ferr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic rxd;
  logic sample_tick;
  logic busy;

  logic ready_cmd;
  logic random_ready;
  logic tick_gaps;

  int compared = 0;
  int mismatched = 0;
  int overruns_seen = 0;
  int overrun_expected = 0;
  int busy_cnt;
  exp_t exp_q[$];

  uart_rx_param_if #(.DATA_BITS(DB)) bus ();

  uart_rx_param #(
    .DATA_BITS  (DB),
    .OVERSAMPLE (OS),
    .PARITY_EN  (PE),
    .PARITY_ODD (PO),
    .STOP_BITS  (SB),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .sample_tick(sample_tick),
    .busy       (busy),
    .rx_bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    bus.rx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.rx_ready = random_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
    end
  end

  initial begin
    sample_tick = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      sample_tick = tick_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the parity bit a correct transmitter would send for this word.
  function automatic logic correctParity(input logic [DB-1:0] d);
    int ones = 0;
    for (int i = 0; i < DB; i++) ones += int'(d[i]);
    return 1'((ones % 2) ^ PO);
  endfunction

  task automatic waitTick();
    do @(posedge clk); while (sample_tick !== 1'b1);
    #1;
  endtask

  task automatic driveBit(input logic b, input int glitch);
    for (int t = 0; t < OS; t++) begin
      rxd = (t == glitch) ? ~b : b;
      waitTick();
    end
  endtask

  task automatic idleBits(input int n);
    rxd = 1'b1;
    repeat (n * OS) waitTick();
  endtask

  task automatic applyStimulus(input logic [DB-1:0] data, input logic par_bit, input logic stop_low,
                               input int glitch, input logic drop);
    exp_t e;
    e.data = data;
    e.perr = (PE != 0) && (par_bit != correctParity(data));
    e.ferr = stop_low;
    if (drop) overrun_expected++;
    else exp_q.push_back(e);
    driveBit(1'b0, -1);
    for (int i = 0; i < DB; i++) driveBit(data[i], glitch);
    if (PE != 0) driveBit(par_bit, glitch);
    for (int s = 0; s < SB; s++) driveBit((s == 0 && stop_low) ? 1'b0 : 1'b1, glitch);
    rxd = 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rx_data"}, 32'(bus.rx_data), 32'd0);
    checkOutput({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
    checkOutput({tag, "_parity_error"}, 32'(bus.parity_error), 32'd0);
    checkOutput({tag, "_frame_error"}, 32'(bus.frame_error), 32'd0);
    checkOutput({tag, "_overrun_error"}, 32'(bus.overrun_error), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Monitor: every accepted word must match the oldest expected frame.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0) begin
      if (bus.overrun_error === 1'b1) overruns_seen++;
      if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_word: got 0x%0h, expected none at %0t", bus.rx_data, $time);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rx_data", 32'(bus.rx_data), 32'(e.data));
          checkOutput("parity_error", 32'(bus.parity_error), 32'(e.perr));
          checkOutput("frame_error", 32'(bus.frame_error), 32'(e.ferr));
        end
      end
    end
  end

  initial begin
    logic [DB-1:0] d;
    logic          pb;
    logic          sl;
    int            wait_cycles;

    reset        = 1'b1;
    rxd          = 1'b1;
    ready_cmd    = 1'b1;
    random_ready = 1'b0;
    tick_gaps    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    idleBits(2);

    $display("[TB] directed frames");
    applyStimulus(8'hA5, 1'b0, 1'b0, -1, 1'b0);
    idleBits(2);
    applyStimulus(8'hA5, 1'b1, 1'b0, -1, 1'b0);
    idleBits(2);
    applyStimulus(8'h3C, correctParity(8'h3C), 1'b1, -1, 1'b0);
    idleBits(2);
    applyStimulus(8'h3C, correctParity(8'h3C), 1'b0, -1, 1'b0);
    idleBits(2);

    $display("[TB] false start");
    fork
      begin
        rxd = 1'b0;
        repeat (4) waitTick();
        rxd = 1'b1;
        repeat (40) waitTick();
      end
      begin
        busy_cnt = 0;
        repeat (44) begin
          @(negedge clk);
          if (busy === 1'b1) busy_cnt++;
        end
      end
    join
    @(negedge clk);
    checkOutput("false_start_busy_ticks", 32'(busy_cnt), 32'd8);
    checkOutput("false_start_no_valid", 32'(bus.rx_valid), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] overrun");
    ready_cmd = 1'b0;
    applyStimulus(8'h11, correctParity(8'h11), 1'b0, -1, 1'b0);
    idleBits(1);
    applyStimulus(8'h22, correctParity(8'h22), 1'b0, -1, 1'b1);
    idleBits(1);
    @(negedge clk);
    checkOutput("overrun_hold_valid", 32'(bus.rx_valid), 32'd1);
    checkOutput("overrun_hold_data", 32'(bus.rx_data), 32'h11);
    checkOutput("overrun_pulses", 32'(overruns_seen), 32'd1);
    @(posedge clk);
    #1;
    ready_cmd = 1'b1;
    idleBits(2);

    $display("[TB] reset mid-frame");
    driveBit(1'b0, -1);
    for (int i = 0; i < 3; i++) driveBit(1'b1, -1);
    repeat (OS / 2) waitTick();
    reset = 1'b1;
    rxd   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkAllZero("midframe_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    idleBits(2);
    applyStimulus(8'h5A, correctParity(8'h5A), 1'b0, -1, 1'b0);
    idleBits(2);

`ifdef UART_RX_MAJORITY_EN
    $display("[TB] majority glitch");
    applyStimulus(8'h96, correctParity(8'h96), 1'b0, OS / 2 - 1, 1'b0);
    idleBits(2);
`endif

    $display("[TB] randomized frames");
    random_ready = 1'b1;
    tick_gaps    = 1'b1;
    for (int n = 0; n < 40; n++) begin
      d  = DB'($urandom);
      pb = correctParity(d) ^ ($urandom_range(0, 3) == 0);
      sl = ($urandom_range(0, 6) == 0);
      applyStimulus(d, pb, sl, -1, 1'b0);
      idleBits(sl ? 2 : int'($urandom_range(0, 2)));
    end

    random_ready = 1'b0;
    tick_gaps    = 1'b0;
    ready_cmd    = 1'b1;
    wait_cycles  = 0;
    while (exp_q.size() != 0 && wait_cycles < 500) begin
      @(posedge clk);
      wait_cycles++;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("queue_drain", 32'(exp_q.size()), 32'd0);
    checkOutput("overrun_total", 32'(overruns_seen), 32'(overrun_expected));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
